byte_match_lock: RTL and testbench
==================================

Name: byte_match_lock

Overview:
Downstream consumer of the 8-bit byte comparator's equality output. It samples the comparator result on each enabled compare and tracks runs of consecutive matches and mismatches. It declares lock after LOCK_CNT consecutive matching bytes and drops lock after UNLOCK_CNT consecutive mismatches. It feeds lock status and match statistics to the surrounding frame/sync logic.

Parameters:
LOCK_CNT, 4, consecutive valid matches needed to enter LOCKED; legal range 1..2^CNT_W-1
UNLOCK_CNT, 3, consecutive valid mismatches needed to leave LOCKED; legal range 1..2^CNT_W-1
CNT_W, 4, width of the run counters

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
cmp_vld  input  1  compare valid; same signal that drives the comparator enable
cmp_eq  input  1  comparator result; 1 = bytes equal; high-Z/X when comparator disabled
clr  input  1  synchronous clear of state and counters
locked  output  1  1 while in LOCKED state
lock_pulse  output  1  one-cycle pulse on SEARCH->LOCKED
unlock_pulse  output  1  one-cycle pulse on LOCKED->SEARCH
match_run  output  CNT_W  current consecutive-match count
miss_run  output  CNT_W  current consecutive-mismatch count, meaningful in LOCKED
match_total  output  16  total valid matches since reset/clr, saturating

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-run): state=SEARCH; locked, lock_pulse, unlock_pulse = 0; match_run, miss_run, match_total = 0. Outputs hold these values until the first rising clk with rst_n=1.
- A sample is taken on a rising clk edge with cmp_vld=1. cmp_eq counts as a match only if exactly 1'b1. 0, X or Z counts as a mismatch.
- cmp_vld=0: no sample. All counters and state hold, pulses return to 0. Idle gaps do not break a run.
- All outputs are registered. The effect of a sample is visible immediately after the sampling edge, so latency is 1 edge.
- State SEARCH:
  - Match: match_total++ (saturate at 16'hFFFF); match_run++.
  - If the incremented match_run equals LOCK_CNT: go to LOCKED, set lock_pulse=1 for one cycle, and set miss_run=0. match_run remains at LOCK_CNT.
  - Mismatch: match_run=0. Stay in SEARCH.
- State LOCKED:
  - Match: match_total++; miss_run=0; match_run++ saturating at 2^CNT_W-1.
  - Mismatch: match_run=0; miss_run++.
  - If the incremented miss_run equals UNLOCK_CNT: go to SEARCH, set unlock_pulse=1 for one cycle, and set miss_run=0.
- miss_run is held at 0 in SEARCH.
- Pulses are 1 only in the cycle following the transition edge. Back-to-back transitions cannot occur within one cycle.
- clr=1 on an edge: same end state as reset. clr has priority over a simultaneous sample; that sample is discarded and not counted.
- LOCK_CNT=1: the first match locks. UNLOCK_CNT=1: the first mismatch unlocks.
- Counters never wrap; all saturate at their maximum value.

Test Plan:
- Reset, then 4 matching samples on consecutive edges -> match_run 1,2,3,4; locked=1 after edge 4; lock_pulse=1 for exactly one cycle; match_total=4.
- 3 matches, 1 mismatch, 4 matches -> no lock after the mismatch (match_run=0); lock after the 8th sample; match_total=7.
- Matches interleaved with cmp_vld=0 idle cycles (cmp_eq=Z during idle) -> idle cycles ignored; lock still reached on the 4th valid match.
- In LOCKED: miss, miss, match, miss, miss, miss -> miss_run 1,2,0,1,2; unlock_pulse and locked=0 after the final miss; match_run=0.
- cmp_vld=1 with cmp_eq=X -> treated as mismatch; clr=1 together with a valid match -> all counters 0, state SEARCH, match not counted.
- Drive rst_n low asynchronously mid-LOCKED between clk edges -> locked and all counters 0 immediately, without waiting for a clock edge; 70000 matches -> match_total saturates at 65535.

Source files
------------

// File: rtl/byte_match_lock.sv
// Lock detector fed by the byte comparator's equality output: counts runs of
// valid matches/mismatches and enters/leaves LOCKED on configurable run lengths.
module byte_match_lock #(
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 3,
   parameter int unsigned CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmp_vld,
   input  logic             cmp_eq,
   input  logic             clr,
   output logic             locked,
   output logic             lock_pulse,
   output logic             unlock_pulse,
   output logic [CNT_W-1:0] match_run,
   output logic [CNT_W-1:0] miss_run,
   output logic [15:0]      match_total
);

   localparam int unsigned TOT_W = 16;
   localparam logic [CNT_W-1:0] RUN_MAX = '1;
   localparam logic [TOT_W-1:0] TOT_MAX = '1;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   match_run_q, match_run_d;
   logic [CNT_W-1:0]   miss_run_q, miss_run_d;
   logic [TOT_W-1:0]   total_q, total_d;
   logic               lock_pulse_q, lock_pulse_d;
   logic               unlock_pulse_q, unlock_pulse_d;

   logic               hit_c;
   logic [CNT_W-1:0]   match_inc_c;
   logic [CNT_W-1:0]   miss_inc_c;
   logic [TOT_W-1:0]   total_inc_c;

   // Only a clean 1 is a match; 0, X and Z all count as mismatches.
   assign hit_c       = (cmp_eq === 1'b1);
   assign match_inc_c = (match_run_q == RUN_MAX) ? RUN_MAX : match_run_q + CNT_W'(1);
   assign miss_inc_c  = (miss_run_q == RUN_MAX) ? RUN_MAX : miss_run_q + CNT_W'(1);
   assign total_inc_c = (total_q == TOT_MAX) ? TOT_MAX : total_q + TOT_W'(1);

   always_comb begin
      state_d        = state_q;
      match_run_d    = match_run_q;
      miss_run_d     = miss_run_q;
      total_d        = total_q;
      lock_pulse_d   = 1'b0;
      unlock_pulse_d = 1'b0;

      if (clr) begin
         state_d     = SEARCH;
         match_run_d = '0;
         miss_run_d  = '0;
         total_d     = '0;
      end else if (cmp_vld) begin
         case (state_q)
            SEARCH: begin
               miss_run_d = '0;
               if (hit_c) begin
                  total_d     = total_inc_c;
                  match_run_d = match_inc_c;
                  if (match_inc_c == CNT_W'(LOCK_CNT)) begin
                     state_d      = LOCKED;
                     lock_pulse_d = 1'b1;
                  end
               end else begin
                  match_run_d = '0;
               end
            end
            LOCKED: begin
               if (hit_c) begin
                  total_d     = total_inc_c;
                  match_run_d = match_inc_c;
                  miss_run_d  = '0;
               end else begin
                  match_run_d = '0;
                  miss_run_d  = miss_inc_c;
                  if (miss_inc_c == CNT_W'(UNLOCK_CNT)) begin
                     state_d        = SEARCH;
                     unlock_pulse_d = 1'b1;
                     miss_run_d     = '0;
                  end
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= SEARCH;
         match_run_q    <= '0;
         miss_run_q     <= '0;
         total_q        <= '0;
         lock_pulse_q   <= 1'b0;
         unlock_pulse_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         match_run_q    <= match_run_d;
         miss_run_q     <= miss_run_d;
         total_q        <= total_d;
         lock_pulse_q   <= lock_pulse_d;
         unlock_pulse_q <= unlock_pulse_d;
      end
   end

   assign locked       = (state_q == LOCKED);
   assign lock_pulse   = lock_pulse_q;
   assign unlock_pulse = unlock_pulse_q;
   assign match_run    = match_run_q;
   assign miss_run     = miss_run_q;
   assign match_total  = total_q;

endmodule

// File: tb/tb_byte_match_lock.sv
// Scoreboard bench for byte_match_lock: a behavioural model predicts every
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_byte_match_lock;

   localparam int unsigned LOCK_CNT   = 4;
   localparam int unsigned UNLOCK_CNT = 3;
   localparam int unsigned CNT_W      = 4;
   localparam int RUN_SAT = (1 << CNT_W) - 1;

   typedef struct packed {
      logic             locked;
      logic             lock_pulse;
      logic             unlock_pulse;
      logic [CNT_W-1:0] match_run;
      logic [CNT_W-1:0] miss_run;
      logic [15:0]      match_total;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   logic cmp_vld;
   logic cmp_eq;
   logic clr;
   logic             locked;
   logic             lock_pulse;
   logic             unlock_pulse;
   logic [CNT_W-1:0] match_run;
   logic [CNT_W-1:0] miss_run;
   logic [15:0]      match_total;

   int errors = 0;
   int checks = 0;

   obs_t sb[$];

   // Behavioural model state
   bit m_lk;
   bit m_lp;
   bit m_up;
   int m_mr;
   int m_ms;
   int m_tot;

   byte_match_lock #(
      .LOCK_CNT  (LOCK_CNT),
      .UNLOCK_CNT(UNLOCK_CNT),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmp_vld     (cmp_vld),
      .cmp_eq      (cmp_eq),
      .clr         (clr),
      .locked      (locked),
      .lock_pulse  (lock_pulse),
      .unlock_pulse(unlock_pulse),
      .match_run   (match_run),
      .miss_run    (miss_run),
      .match_total (match_total)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic obs_t observe();
      obs_t o;
      o.locked       = locked;
      o.lock_pulse   = lock_pulse;
      o.unlock_pulse = unlock_pulse;
      o.match_run    = match_run;
      o.miss_run     = miss_run;
      o.match_total  = match_total;
      return o;
   endfunction

   function automatic obs_t model_snapshot();
      obs_t o;
      o.locked       = m_lk;
      o.lock_pulse   = m_lp;
      o.unlock_pulse = m_up;
      o.match_run    = CNT_W'(m_mr);
      o.miss_run     = CNT_W'(m_ms);
      o.match_total  = 16'(m_tot);
      return o;
   endfunction

   task automatic model_reset();
      m_lk = 0; m_lp = 0; m_up = 0; m_mr = 0; m_ms = 0; m_tot = 0;
   endtask

   task automatic model_step(input logic vld, input logic eq, input logic c);
      bit hit;
      hit  = (eq === 1'b1);
      m_lp = 0;
      m_up = 0;
      if (c) begin
         model_reset();
      end else if (vld) begin
         if (hit) begin
            if (m_tot < 65535) m_tot++;
            if (m_mr < RUN_SAT) m_mr++;
         end
         if (!m_lk) begin
            if (!hit) m_mr = 0;
            else if (m_mr == LOCK_CNT) begin
               m_lk = 1; m_lp = 1; m_ms = 0;
            end
         end else if (hit) begin
            m_ms = 0;
         end else begin
            m_mr = 0;
            m_ms++;
            if (m_ms == UNLOCK_CNT) begin
               m_lk = 0; m_up = 1; m_ms = 0;
            end
         end
      end
   endtask

   // Drive one cycle, queue the predicted outputs, advance past the edge.
   task automatic drive(input logic vld, input logic eq, input logic c);
      cmp_vld = vld;
      cmp_eq  = eq;
      clr     = c;
      model_step(vld, eq, c);
      sb.push_back(model_snapshot());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t o;
      rst_n = 1'b0; cmp_vld = 1'b0; cmp_eq = 1'bz; clr = 1'b0;
      model_reset();
      #3;
      o = observe();
      checks++;
      if (o !== obs_t'(0)) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", o, obs_t'(0));
      end
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_lock();
      obs_t e, o;
      drive(1'b0, 1'bz, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, (i < 4) ? 1'b1 : 1'b0, 1'b0);
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL basic_lock[%0d]: got %h expected %h", i, o, e);
         end
         if (i == 3) begin
            checks++;
            if (locked !== 1'b1 || lock_pulse !== 1'b1 || match_total !== 16'd4 || match_run !== 4'd4) begin
               errors++;
               $display("FAIL basic_lock_edge4: got locked=%b pulse=%b run=%0d total=%0d expected 1 1 4 4",
                        locked, lock_pulse, match_run, match_total);
            end
         end
      end
   endtask

   task automatic test_broken_run();
      obs_t e, o;
      logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      drive(1'b0, 1'bz, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, pat[i], 1'b0);
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL broken_run[%0d]: got %h expected %h", i, o, e);
         end
      end
      checks++;
      if (locked !== 1'b1 || match_total !== 16'd7) begin
         errors++;
         $display("FAIL broken_run_end: got locked=%b total=%0d expected locked=1 total=7", locked, match_total);
      end
   endtask

   task automatic test_idle_gaps();
      obs_t e, o;
      drive(1'b0, 1'bz, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 12; i++) begin
         if (i % 3 == 2) drive(1'b1, 1'b1, 1'b0);
         else            drive(1'b0, 1'bz, 1'b0);
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL idle_gaps[%0d]: got %h expected %h", i, o, e);
         end
      end
      checks++;
      if (locked !== 1'b1 || match_run !== 4'd4) begin
         errors++;
         $display("FAIL idle_gaps_lock: got locked=%b run=%0d expected locked=1 run=4", locked, match_run);
      end
   endtask

   task automatic test_unlock();
      obs_t e, o;
      logic pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [CNT_W-1:0] want_miss [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, pat[i], 1'b0);
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e || miss_run !== want_miss[i]) begin
            errors++;
            $display("FAIL unlock[%0d]: got %h expected %h (miss_run want %0d)", i, o, e, want_miss[i]);
         end
      end
      checks++;
      if (locked !== 1'b0 || unlock_pulse !== 1'b1 || match_run !== '0) begin
         errors++;
         $display("FAIL unlock_end: got locked=%b pulse=%b run=%0d expected 0 1 0", locked, unlock_pulse, match_run);
      end
      drive(1'b0, 1'bz, 1'b0);
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL unlock_pulse_width: got %h expected %h", o, e);
      end
   endtask

   task automatic test_x_and_clr();
      obs_t e, o;
      drive(1'b0, 1'bz, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 6; i++) begin
         if (i == 2) drive(1'b1, 1'bx, 1'b0);
         else if (i == 5) drive(1'b1, 1'b1, 1'b1);
         else drive(1'b1, 1'b1, 1'b0);
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL x_and_clr[%0d]: got %h expected %h", i, o, e);
         end
      end
      checks++;
      if ({locked, match_run, miss_run, match_total} !== '0) begin
         errors++;
         $display("FAIL clr_priority: got locked=%b run=%0d miss=%0d total=%0d expected all 0",
                  locked, match_run, miss_run, match_total);
      end
   endtask

   task automatic test_async_reset();
      obs_t e, o;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL async_pre[%0d]: got %h expected %h", i, o, e);
         end
      end
      cmp_vld = 1'b0; cmp_eq = 1'bz;
      @(negedge clk); #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      o = observe();
      checks++;
      if (o !== obs_t'(0)) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", o, obs_t'(0));
      end
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      obs_t e, o;
      int bad = 0;
      for (int i = 0; i < 70000; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            bad++;
            if (bad <= 5) $display("FAIL saturation[%0d]: got %h expected %h", i, o, e);
         end
      end
      checks++;
      if (match_total !== 16'hFFFF || match_run !== 4'hF || locked !== 1'b1) begin
         errors++;
         $display("FAIL saturation_end: got total=%h run=%h locked=%b expected ffff f 1",
                  match_total, match_run, locked);
      end
   endtask

   initial begin
      test_reset();
      test_basic_lock();
      test_broken_run();
      test_idle_gaps();
      test_unlock();
      test_x_and_clr();
      test_async_reset();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
